and_serial_ctrl: RTL

Bit-serial sequencer for the AND datapath: it accepts an INPUT_WIDTH-bit operand through a valid/ready handshake and reduces it to a single AND result using one shared `and_B_to_A` cell. It does this by stepping one operand bit per clock through the cell instead of instantiating an INPUT_WIDTH-deep chain. It sits between a requesting unit and the gate-level AND logic, trading latency for area, and supervises the DigitSupply rail during operation.

---
 rtl/and_serial_ctrl_pkg.sv | 17 +
 rtl/and_B_to_A.sv | 13 +
 rtl/and_serial_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/and_serial_ctrl_pkg.sv
// Shared types and constants for the bit-serial AND sequencer.
package and_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ctrlStateT;

  localparam logic [1:0] SUPPLY_OK = 2'b10;

  // Counter wide enough to hold 0..width inclusive.
  function automatic int unsigned cntWidth(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/and_B_to_A.sv
// Single AND cell: folds operand bit B into running value A; dead rail forces 0.
module and_B_to_A
  import and_serial_ctrl_pkg::*;
(
  input  logic       A,
  input  logic       B,
  input  logic [1:0] DigitSupply,
  output logic       Y
);

  assign Y = (DigitSupply == SUPPLY_OK) & A & B;

endmodule

// File: rtl/and_serial_ctrl.sv
// Bit-serial AND reduction sequencer: one shared cell, one operand bit per clock,
// with early exit on a zero bit and abort on a bad DigitSupply rail.
module and_serial_ctrl
  import and_serial_ctrl_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter bit          EARLY_EXIT  = 1'b1
) (
  input  logic                                 Clock,
  input  logic                                 Reset,
  input  logic [1:0]                           DigitSupply,
  input  logic                                 startValid,
  output logic                                 startReady,
  input  logic [INPUT_WIDTH-1:0]               inputData,
  output logic                                 resultValid,
  input  logic                                 resultReady,
  output logic                                 outputData,
  output logic [cntWidth(INPUT_WIDTH)-1:0]     bitsUsed,
  output logic                                 supplyFault
);

  localparam int unsigned    CW       = cntWidth(INPUT_WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(INPUT_WIDTH - 1);

  ctrlStateT              state;
  logic [INPUT_WIDTH-1:0] shiftReg;
  logic [CW-1:0]          index;
  logic                   acc;
  logic                   cellOut;
  logic                   curBit;
  logic                   lastBit;
  logic                   zeroExit;
  logic                   supplyBad;

  // Operand is shifted right each step so the current bit is always bit 0.
  assign curBit     = shiftReg[0];
  assign lastBit    = (index == LAST_IDX);
  assign zeroExit   = EARLY_EXIT && !curBit;
  assign supplyBad  = (DigitSupply != SUPPLY_OK);
  assign startReady = (state == IDLE) && !Reset;

  and_B_to_A uCell (
    .A           (acc),
    .B           (curBit),
    .DigitSupply (DigitSupply),
    .Y           (cellOut)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      shiftReg    <= '0;
      index       <= '0;
      acc         <= 1'b1;
      outputData  <= 1'b0;
      resultValid <= 1'b0;
      bitsUsed    <= '0;
      supplyFault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startValid) begin
            shiftReg    <= inputData;
            acc         <= 1'b1;
            index       <= '0;
            supplyFault <= 1'b0;
            state       <= RUN;
          end
        end

        RUN: begin
          acc <= cellOut;
          // Fault wins over completion; the faulting bit is not counted.
          if (supplyBad) begin
            outputData  <= 1'b0;
            supplyFault <= 1'b1;
            bitsUsed    <= index;
            resultValid <= 1'b1;
            state       <= DONE;
          end else begin
            bitsUsed <= index + CW'(1);
            if (lastBit || zeroExit) begin
              outputData  <= cellOut;
              resultValid <= 1'b1;
              state       <= DONE;
            end else begin
              index    <= index + CW'(1);
              shiftReg <= shiftReg >> 1;
            end
          end
        end

        DONE: begin
          if (resultReady) begin
            resultValid <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
